test_vector_driver: RTL and testbench

- Self-checking stimulus/check sequencer for one operator test, the producer side of the fail/finish protocol the top-level test aggregator consumes.
- Drives operand vectors from parameter ROMs into a DUT and compares the DUT result against expected values after a fixed DUT latency.
- Reports a sticky fail with the failing index, and a sticky finish.
- One instance per operator test (add, sub, mul, logic ops, reg/mul pipelines).

---
 rtl/test_vector_driver.sv | 112 +++++++++++
 tb/tb_test_vector_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_vector_driver.sv
// Stimulus/check sequencer for one operator test: plays operand ROMs into a DUT,
// compares its result LATENCY cycles later, and reports sticky fail/fail_index/finish.
module test_vector_driver #(
   parameter int WIDTH       = 8,
   parameter int NUM_VECTORS = 8,
   parameter int LATENCY     = 0,
   parameter logic [NUM_VECTORS*WIDTH-1:0] VEC_A = '0,
   parameter logic [NUM_VECTORS*WIDTH-1:0] VEC_B = '0,
   parameter logic [NUM_VECTORS*WIDTH-1:0] VEC_Y = '0
) (
   input  logic             clock,
   input  logic             reset,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] y,
   output logic             fail,
   output logic [7:0]       fail_index,
   output logic             finish
);

   localparam int CW = $clog2(NUM_VECTORS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_VECTORS - 1);
   localparam logic [CW-1:0] FULL = CW'(NUM_VECTORS);

   typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_iss_cnt;
   logic [CW-1:0]    r_chk_cnt;
   logic [LATENCY:0] r_vld_pipe;
   logic [WIDTH-1:0] r_exp_pipe [0:LATENCY];

   logic [CW-1:0]    w_rom_idx;
   logic [WIDTH-1:0] w_vec_a;
   logic [WIDTH-1:0] w_vec_b;
   logic [WIDTH-1:0] w_vec_y;
   logic             w_chk;
   logic             w_mismatch;
   logic             w_last_chk;

   // Counters stop at NUM_VECTORS instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= FULL) ? v : v + 1'b1;
   endfunction

   always_comb begin
      w_rom_idx  = (r_iss_cnt > LAST) ? LAST : r_iss_cnt;
      w_vec_a    = VEC_A[int'(w_rom_idx)*WIDTH +: WIDTH];
      w_vec_b    = VEC_B[int'(w_rom_idx)*WIDTH +: WIDTH];
      w_vec_y    = VEC_Y[int'(w_rom_idx)*WIDTH +: WIDTH];
      w_chk      = r_vld_pipe[LATENCY];
      w_mismatch = w_chk && (y != r_exp_pipe[LATENCY]);
      w_last_chk = w_chk && (r_chk_cnt == LAST);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         a          <= '0;
         b          <= '0;
         fail       <= 1'b0;
         fail_index <= '0;
         finish     <= 1'b0;
         r_iss_cnt  <= '0;
         r_chk_cnt  <= '0;
         r_vld_pipe <= '0;
         for (int k = 0; k <= LATENCY; k++) begin
            r_exp_pipe[k] <= '0;
         end
      end else begin
         // Stage 0 lines up with a/b; stage LATENCY lines up with y.
         for (int k = LATENCY; k > 0; k--) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_exp_pipe[k] <= r_exp_pipe[k-1];
         end
         r_vld_pipe[0] <= 1'b0;
         r_exp_pipe[0] <= w_vec_y;

         case (r_state)
            IDLE: r_state <= DRIVE;
            DRIVE: begin
               a             <= w_vec_a;
               b             <= w_vec_b;
               r_vld_pipe[0] <= 1'b1;
               r_iss_cnt     <= sat_inc(r_iss_cnt);
               if (r_iss_cnt == LAST) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_last_chk) begin
                  r_state <= DONE;
               end
            end
            DONE: finish <= 1'b1;
            default: r_state <= IDLE;
         endcase

         if (w_chk) begin
            r_chk_cnt <= sat_inc(r_chk_cnt);
            if (w_mismatch && !fail) begin
               fail       <= 1'b1;
               fail_index <= 8'(r_chk_cnt);
            end
            if (w_last_chk) begin
               finish <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_test_vector_driver.sv
// Five driver instances (add, add with bad ROM entry, 2-stage mul, latency mismatch,
// single vector) against behavioural operator stubs with random result corruption.
module tb_test_vector_driver;

   typedef struct {
      bit f;
      int idx;
      int fcyc;
      int fincyc;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [7:0] a_w [5];
   logic [7:0] b_w [5];
   logic [7:0] fi_w [5];
   logic       fail_w [5];
   logic       fin_w [5];
   logic [7:0] inj_set [5];
   logic [7:0] inj_val [5];
   bit         armed;
   int         cyc;
   int         n_chk;
   int         n_fail;
   exp_t       q [5][$];

   function automatic int nv_f(input int g);
      case (g)
         0: return 4;
         1: return 8;
         2: return 4;
         3: return 4;
         default: return 1;
      endcase
   endfunction

   // Latency the driver is configured with.
   function automatic int lat_f(input int g);
      return (g == 2) ? 2 : (g == 3) ? 1 : 0;
   endfunction

   // Latency the stub operator really has.
   function automatic int rl_f(input int g);
      return (g == 2) ? 2 : 0;
   endfunction

   function automatic logic [63:0] romA(input int g);
      case (g)
         0: return 64'h7F1280FF;
         1: return 64'hF077665544332211;
         2: return 64'hFF0F0310;
         3: return 64'h04030201;
         default: return 64'h7F;
      endcase
   endfunction

   function automatic logic [63:0] romB(input int g);
      case (g)
         0: return 64'h01348001;
         1: return 64'h2007060504030201;
         2: return 64'hFF110510;
         3: return 64'h40302010;
         default: return 64'h01;
      endcase
   endfunction

   // Instance 1 carries a deliberately wrong entry 0x55 at vector 3.
   function automatic logic [63:0] romY(input int g);
      case (g)
         0: return 64'h80460000;
         1: return 64'h107E6C5A55362412;
         2: return 64'h01FF0F00;
         3: return 64'h44332211;
         default: return 64'h80;
      endcase
   endfunction

   function automatic logic [7:0] rb(input logic [63:0] r, input int i);
      return r[i*8 +: 8];
   endfunction

   function automatic logic [7:0] fop(input int g, input logic [7:0] x, input logic [7:0] z);
      logic [15:0] p;
      if (g == 2) begin
         p = 16'(x) * 16'(z);
         return p[7:0];
      end
      return x + z;
   endfunction

   // Expected outcome of one full pass from reset release.
   function automatic exp_t model(input int g);
      exp_t e;
      int   nv;
      int   lt;
      int   v;
      int   first;
      logic [7:0] seen;
      nv = nv_f(g);
      lt = lat_f(g);
      first = -1;
      for (int k = 0; k < nv; k++) begin
         v = k + lt - rl_f(g);
         if (v > nv - 1) v = nv - 1;
         seen = fop(g, rb(romA(g), v), rb(romB(g), v));
         if (inj_set[g][k]) seen = seen ^ inj_val[g];
         if (seen != rb(romY(g), k) && first < 0) first = k;
      end
      e.f      = (first >= 0);
      e.idx    = (first >= 0) ? first : 0;
      e.fcyc   = 3 + first + lt;
      e.fincyc = nv + lt + 2;
      return e;
   endfunction

   function automatic bit pending();
      for (int g = 0; g < 5; g++) begin
         if (q[g].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   for (genvar g = 0; g < 5; g++) begin : inst
      localparam int NV = nv_f(g);
      localparam int LT = lat_f(g);
      localparam int RL = rl_f(g);
      localparam int BW = NV * 8;
      localparam logic [BW-1:0] PA = BW'(romA(g));
      localparam logic [BW-1:0] PB = BW'(romB(g));
      localparam logic [BW-1:0] PY = BW'(romY(g));

      logic [7:0] yl;
      logic [7:0] p1;
      logic [7:0] p2;
      int         k;
      bit         pf;
      bit         pfin;

      test_vector_driver #(
         .WIDTH(8), .NUM_VECTORS(NV), .LATENCY(LT),
         .VEC_A(PA), .VEC_B(PB), .VEC_Y(PY)
      ) dut (
         .clock(clock), .reset(reset), .a(a_w[g]), .b(b_w[g]), .y(yl),
         .fail(fail_w[g]), .fail_index(fi_w[g]), .finish(fin_w[g])
      );

      always_ff @(posedge clock) begin
         p1 <= fop(g, a_w[g], b_w[g]);
         p2 <= p1;
      end

      // Corrupt the result in the cycle the driver checks vector k.
      always_comb begin
         k  = cyc - 2 - LT;
         yl = (RL == 0) ? fop(g, a_w[g], b_w[g]) : p2;
         if (k >= 0 && k < NV) begin
            if (inj_set[g][k]) yl = yl ^ inj_val[g];
         end
      end

      initial begin
         pf = 1'b0;
         pfin = 1'b0;
         forever begin
            @(negedge clock);
            if (reset) begin
               pf = 1'b0;
               pfin = 1'b0;
            end else begin
               int v;
               v = (cyc < 2) ? -1 : ((cyc - 2 > NV - 1) ? NV - 1 : cyc - 2);
               chk($sformatf("g%0d a", g), int'(a_w[g]), (v < 0) ? 0 : int'(rb(romA(g), v)));
               chk($sformatf("g%0d b", g), int'(b_w[g]), (v < 0) ? 0 : int'(rb(romB(g), v)));
               if (armed && fail_w[g] && !pf) begin
                  if (q[g].size() == 0) begin
                     chk($sformatf("g%0d fail_no_pass", g), int'(fail_w[g]), 0);
                  end else begin
                     chk($sformatf("g%0d fail_rise", g), int'(fail_w[g]), int'(q[g][0].f));
                     chk($sformatf("g%0d fail_cyc", g), cyc, q[g][0].fcyc);
                     chk($sformatf("g%0d fail_index", g), int'(fi_w[g]), q[g][0].idx);
                  end
               end
               if (armed && fin_w[g] && !pfin) begin
                  if (q[g].size() == 0) begin
                     chk($sformatf("g%0d finish_no_pass", g), int'(fin_w[g]), 0);
                  end else begin
                     chk($sformatf("g%0d finish_cyc", g), cyc, q[g][0].fincyc);
                     chk($sformatf("g%0d fail_at_finish", g), int'(fail_w[g]), int'(q[g][0].f));
                     chk($sformatf("g%0d index_at_finish", g), int'(fi_w[g]), q[g][0].idx);
                     void'(q[g].pop_front());
                  end
               end
               pf = fail_w[g];
               pfin = fin_w[g];
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      armed = 1'b0;
      reset = 1'b1;
      for (int g = 0; g < 5; g++) begin
         inj_set[g] = '0;
         inj_val[g] = '0;
      end
      repeat (2) @(posedge clock);
      for (int t = 0; t < 14; t++) begin
         bit ab;
         ab = (t % 4 == 1);
         for (int g = 0; g < 5; g++) begin
            if (ab || g == 3 || $urandom_range(0, 2) == 0) inj_set[g] = '0;
            else inj_set[g] = 8'($urandom) & 8'((1 << nv_f(g)) - 1);
            inj_val[g] = 8'($urandom_range(1, 255));
            if (!ab) q[g].push_back(model(g));
         end
         armed = !ab;
         @(negedge clock);
         #1 reset = 1'b0;
         if (ab) begin
            int stop;
            stop = (t == 1) ? 6 : $urandom_range(2, 9);
            while (cyc < stop) begin
               @(posedge clock);
               #2;
            end
         end else begin
            int w;
            w = 0;
            while (pending() && w < 60) begin
               @(posedge clock);
               #2;
               w++;
            end
            for (int g = 0; g < 5; g++) begin
               if (q[g].size() != 0) begin
                  chk($sformatf("g%0d timeout_pending", g), q[g].size(), 0);
                  q[g].delete();
               end
            end
            repeat (2) @(posedge clock);
            #2;
         end
         reset = 1'b1;
         #1;
         for (int g = 0; g < 5; g++) begin
            chk($sformatf("g%0d reset_a", g), int'(a_w[g]), 0);
            chk($sformatf("g%0d reset_b", g), int'(b_w[g]), 0);
            chk($sformatf("g%0d reset_fail", g), int'(fail_w[g]), 0);
            chk($sformatf("g%0d reset_index", g), int'(fi_w[g]), 0);
            chk($sformatf("g%0d reset_finish", g), int'(fin_w[g]), 0);
         end
         repeat ($urandom_range(1, 3)) @(posedge clock);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
